// File: rtl/ttt_game_ctrl.sv
// Tic-tac-toe game controller: owns the 9-cell board, alternates turns, validates moves,
// and evaluates win/tie one cycle after each accepted move. Optional macro: MOVE_TIMEOUT_EN.
module ttt_game_ctrl #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        new_game,
    input  logic        move_valid,
    input  logic [3:0]  move_pos,
    output logic        move_ready,
    output logic [17:0] board,
    output logic [1:0]  turn,
    output logic [1:0]  status,
    output logic        game_over,
    output logic        move_err,
    output logic [3:0]  move_count
);

    typedef enum logic [1:0] {S_IDLE, S_TURN, S_EVAL, S_DONE} state_t;

    state_t      state_q, state_d;
    logic [17:0] board_q, board_d;
    logic [1:0]  player_q, player_d;
    logic [1:0]  status_q, status_d;
    logic [3:0]  count_q, count_d;
    logic        err_q, err_d;
    logic        legal;
    logic [1:0]  target_cell;
    logic [1:0]  win;

    if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 2");
    end

`ifdef MOVE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    logic [TW-1:0] tmo_q, tmo_d;
`endif

    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] p);
        logic [1:0] c;
        c = 2'b00;
        for (int i = 0; i < 9; i++) begin
            if (p == 4'(i)) c = b[2*i +: 2];
        end
        return c;
    endfunction

    function automatic logic [1:0] line_owner(input logic [17:0] b, input int a, input int m,
                                              input int z);
        if (b[2*a +: 2] != 2'b00 && b[2*a +: 2] == b[2*m +: 2] && b[2*a +: 2] == b[2*z +: 2])
            return b[2*a +: 2];
        return 2'b00;
    endfunction

    // First matching line in row, column, diagonal order decides the owner.
    function automatic logic [1:0] find_winner(input logic [17:0] b);
        logic [1:0] w;
        w = line_owner(b, 0, 1, 2);
        if (w == 2'b00) w = line_owner(b, 3, 4, 5);
        if (w == 2'b00) w = line_owner(b, 6, 7, 8);
        if (w == 2'b00) w = line_owner(b, 0, 3, 6);
        if (w == 2'b00) w = line_owner(b, 1, 4, 7);
        if (w == 2'b00) w = line_owner(b, 2, 5, 8);
        if (w == 2'b00) w = line_owner(b, 0, 4, 8);
        if (w == 2'b00) w = line_owner(b, 2, 4, 6);
        return w;
    endfunction

    assign target_cell = cell_at(board_q, move_pos);
    assign legal       = move_valid && (move_pos <= 4'd8) && (target_cell == 2'b00);
    assign win         = find_winner(board_q);

    always_comb begin
        state_d  = state_q;
        board_d  = board_q;
        player_d = player_q;
        status_d = status_q;
        count_d  = count_q;
        err_d    = 1'b0;
`ifdef MOVE_TIMEOUT_EN
        tmo_d    = tmo_q;
`endif
        if (new_game) begin
            state_d  = S_TURN;
            board_d  = '0;
            player_d = 2'b01;
            status_d = 2'b00;
            count_d  = 4'd0;
`ifdef MOVE_TIMEOUT_EN
            tmo_d    = '0;
`endif
        end else begin
            case (state_q)
                S_TURN: begin
                    if (legal) begin
                        for (int i = 0; i < 9; i++) begin
                            if (move_pos == 4'(i)) board_d[2*i +: 2] = player_q;
                        end
                        count_d = count_q + 4'd1;
                        state_d = S_EVAL;
                    end else begin
                        err_d = move_valid;
`ifdef MOVE_TIMEOUT_EN
                        // Forfeit: the idle player's opponent takes the game.
                        if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                            state_d  = S_DONE;
                            status_d = {player_q[0], player_q[1]};
                        end else begin
                            tmo_d = tmo_q + 1'b1;
                        end
`endif
                    end
                end
                S_EVAL: begin
                    if (win != 2'b00) begin
                        status_d = win;
                        state_d  = S_DONE;
                    end else if (count_q == 4'd9) begin
                        status_d = 2'b11;
                        state_d  = S_DONE;
                    end else begin
                        player_d = {player_q[0], player_q[1]};
                        state_d  = S_TURN;
`ifdef MOVE_TIMEOUT_EN
                        tmo_d    = '0;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            board_q  <= '0;
            player_q <= 2'b01;
            status_q <= 2'b00;
            count_q  <= 4'd0;
            err_q    <= 1'b0;
`ifdef MOVE_TIMEOUT_EN
            tmo_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            board_q  <= board_d;
            player_q <= player_d;
            status_q <= status_d;
            count_q  <= count_d;
            err_q    <= err_d;
`ifdef MOVE_TIMEOUT_EN
            tmo_q    <= tmo_d;
`endif
        end
    end

    assign move_ready = (state_q == S_TURN);
    assign turn       = (state_q == S_TURN) ? player_q : 2'b00;
    assign game_over  = (state_q == S_DONE);
    assign board      = board_q;
    assign status     = status_q;
    assign move_err   = err_q;
    assign move_count = count_q;

endmodule

// File: tb/tb_ttt_game_ctrl.sv
// Directed bench for ttt_game_ctrl: a small board model feeds an expected-value queue
// that is popped and checked when the controller responds.
module tb_ttt_game_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        new_game = 1'b0;
    logic        move_valid = 1'b0;
    logic [3:0]  move_pos = 4'd0;
    logic        move_ready;
    logic [17:0] board;
    logic [1:0]  turn;
    logic [1:0]  status;
    logic        game_over;
    logic        move_err;
    logic [3:0]  move_count;

    logic [31:0] exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    logic [17:0] m_board;
    logic [1:0]  m_player;
    int          m_count;
    int          lines[8][3] = '{'{0, 1, 2}, '{3, 4, 5}, '{6, 7, 8}, '{0, 3, 6},
                                 '{1, 4, 7}, '{2, 5, 8}, '{0, 4, 8}, '{2, 4, 6}};

    ttt_game_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .new_game   (new_game),
        .move_valid (move_valid),
        .move_pos   (move_pos),
        .move_ready (move_ready),
        .board      (board),
        .turn       (turn),
        .status     (status),
        .game_over  (game_over),
        .move_err   (move_err),
        .move_count (move_count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed so far", n_pass, n_total);
        $fatal(1, "time limit");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $error("FAIL %s: observed %0h, no expected value queued", tag, obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e) n_pass++;
            else $error("FAIL %s: observed %0h expected %0h", tag, obs, e);
        end
    endtask

    function automatic logic [1:0] m_winner();
        logic [1:0] a, b, c;
        for (int l = 0; l < 8; l++) begin
            a = m_board[2*lines[l][0] +: 2];
            b = m_board[2*lines[l][1] +: 2];
            c = m_board[2*lines[l][2] +: 2];
            if (a != 2'b00 && a == b && b == c) return a;
        end
        return 2'b00;
    endfunction

    task automatic expect_reset_values();
        push(32'd0); chk("rst_board", 32'(board));
        push(32'd0); chk("rst_turn", 32'(turn));
        push(32'd0); chk("rst_ready", 32'(move_ready));
        push(32'd0); chk("rst_status", 32'(status));
        push(32'd0); chk("rst_game_over", 32'(game_over));
        push(32'd0); chk("rst_move_err", 32'(move_err));
        push(32'd0); chk("rst_count", 32'(move_count));
    endtask

    task automatic start_game(input string tag);
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        m_board  = '0;
        m_player = 2'b01;
        m_count  = 0;
        push(32'd0); push(32'd1); push(32'd1); push(32'd0); push(32'd0); push(32'd0);
        chk({tag, "_board"}, 32'(board));
        chk({tag, "_turn"}, 32'(turn));
        chk({tag, "_ready"}, 32'(move_ready));
        chk({tag, "_status"}, 32'(status));
        chk({tag, "_count"}, 32'(move_count));
        chk({tag, "_game_over"}, 32'(game_over));
    endtask

    // move_valid stays high through the EVAL cycle: it must be ignored there.
    task automatic play(input int pos);
        logic [1:0] w, e_status, e_turn;
        logic       e_done;
        m_board[2*pos +: 2] = m_player;
        m_count++;
        w = m_winner();
        if (w != 2'b00) begin
            e_status = w; e_done = 1'b1; e_turn = 2'b00;
        end else if (m_count == 9) begin
            e_status = 2'b11; e_done = 1'b1; e_turn = 2'b00;
        end else begin
            m_player = (m_player == 2'b01) ? 2'b10 : 2'b01;
            e_status = 2'b00; e_done = 1'b0; e_turn = m_player;
        end
        push(32'(m_board)); push(32'd0); push(32'd0); push(32'(m_count));
        push(32'd0); push(32'(e_status)); push(32'(e_done)); push(32'(e_turn));
        push(32'(m_count)); push(32'(!e_done));
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        step();
        chk("acc_board", 32'(board));
        chk("acc_ready", 32'(move_ready));
        chk("acc_turn", 32'(turn));
        chk("acc_count", 32'(move_count));
        step();
        move_valid = 1'b0;
        chk("eval_err", 32'(move_err));
        chk("eval_status", 32'(status));
        chk("eval_game_over", 32'(game_over));
        chk("eval_turn", 32'(turn));
        chk("eval_count", 32'(move_count));
        chk("eval_ready", 32'(move_ready));
    endtask

    task automatic bad_move(input int pos, input string tag);
        push(32'd1); push(32'(m_board)); push(32'(m_player)); push(32'd0);
        move_valid = 1'b1;
        move_pos   = 4'(pos);
        step();
        move_valid = 1'b0;
        chk({tag, "_err"}, 32'(move_err));
        chk({tag, "_board"}, 32'(board));
        chk({tag, "_turn"}, 32'(turn));
        step();
        chk({tag, "_err_cleared"}, 32'(move_err));
    endtask

    initial begin
        // Asynchronous reset, no clock edge between assertion and check.
        #2 reset_n = 1'b0;
        #2 expect_reset_values();
        step();
        reset_n = 1'b1;
        step();

        // IDLE ignores moves.
        move_valid = 1'b1; move_pos = 4'd0;
        step();
        move_valid = 1'b0;
        push(32'd0); push(32'd0); push(32'd0);
        chk("idle_err", 32'(move_err));
        chk("idle_board", 32'(board));
        chk("idle_ready", 32'(move_ready));

        // Diagonal win for player 1 with two rejected moves along the way.
        start_game("ng1");
        play(0); play(1); play(4);
        bad_move(4, "occupied");
        bad_move(9, "pos9");
        play(2); play(8);
        push(32'd1); chk("cell8_p1", 32'(board[17:16]));

        // DONE ignores moves and holds the result.
        move_valid = 1'b1; move_pos = 4'd3;
        step(); step();
        move_valid = 1'b0;
        push(32'(m_board)); push(32'd0); push(32'd0); push(32'd1); push(32'd5);
        chk("done_board", 32'(board));
        chk("done_err", 32'(move_err));
        chk("done_turn", 32'(turn));
        chk("done_status", 32'(status));
        chk("done_count", 32'(move_count));

        start_game("ng_done");
        foreach (lines[i]) begin end
        play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(6); play(8);
        push(32'd3); chk("tie_status", 32'(status));

        start_game("ng_tie");
        play(0); play(1); play(2); play(4); play(3); play(5); play(7); play(8); play(6);
        push(32'd1); chk("win9_status", 32'(status));
        push(32'd9); chk("win9_count", 32'(move_count));

        // new_game during EVAL.
        start_game("ng_win9");
        move_valid = 1'b1; move_pos = 4'd0;
        step();
        move_valid = 1'b0;
        new_game = 1'b1;
        step();
        new_game = 1'b0;
        push(32'd0); push(32'd1); push(32'd0); push(32'd1);
        chk("ng_eval_board", 32'(board));
        chk("ng_eval_turn", 32'(turn));
        chk("ng_eval_count", 32'(move_count));
        chk("ng_eval_ready", 32'(move_ready));

        // new_game and a move on the same edge: the move is dropped.
        new_game = 1'b1; move_valid = 1'b1; move_pos = 4'd4;
        step();
        new_game = 1'b0; move_valid = 1'b0;
        push(32'd0); push(32'd0); push(32'd0); push(32'd1);
        chk("ng_mv_board", 32'(board));
        chk("ng_mv_err", 32'(move_err));
        chk("ng_mv_count", 32'(move_count));
        chk("ng_mv_turn", 32'(turn));

        // Reset pulsed mid-turn.
        m_board = '0; m_player = 2'b01; m_count = 0;
        play(5);
        reset_n = 1'b0;
        #2 expect_reset_values();
        reset_n = 1'b1;
        step();

`ifdef MOVE_TIMEOUT_EN
        // Player 2 idles: forfeit exactly 8 edges after its turn starts.
        start_game("ng_tmo");
        play(0);
        for (int i = 1; i < 8; i++) begin
            step();
            push(32'd2); push(32'd0);
            chk("tmo_wait_turn", 32'(turn));
            chk("tmo_wait_over", 32'(game_over));
        end
        step();
        push(32'd1); push(32'd1); push(32'd0);
        chk("tmo_over", 32'(game_over));
        chk("tmo_status", 32'(status));
        chk("tmo_turn", 32'(turn));
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
